pc_gen: RTL and testbench

Parametrised program-counter generator that supersedes the single-register PC. It adds a fetch valid/ready handshake, stall, branch and trap redirects with fixed priority, and misaligned-target detection. It also adds halt/resume and a fetch counter. It sits between the control/branch unit and instruction memory, and drives the fetch address every cycle.

---
 rtl/pc_gen.sv | 145 ++++++++++++++
 tb/tb_pc_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen - program-counter generator with fetch handshake and redirects
//
// Drives the instruction-fetch address every cycle. The PC advances by INC on
// every accepted fetch (valid & ready). Trap and branch redirects override any
// pending un-accepted fetch. Halt/resume suspends and restarts fetching, and a
// counter tracks accepted fetches.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_en                    global enable (0: clear or hold the PC)
//   i_trap, i_trap_target   trap redirect request and handler address
//   i_br_taken, i_br_target branch/jump redirect request and target
//   i_halt, i_resume        enter / leave the HALT state
//   i_stall                 freeze the PC this cycle
//   i_fetch_ready           imem accepts the current address
//   o_pc                    current fetch address (registered)
//   o_pc_plus               o_pc + INC (combinational)
//   o_fetch_valid           o_pc is a valid fetch request (combinational)
//   o_misaligned            one-cycle pulse after a misaligned branch target
//   o_halted                FSM is in HALT (registered)
//   o_fetch_cnt             number of accepted fetches (registered)
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int                XLEN           = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR   = {XLEN{1'b0}},
    parameter int                INC            = 4,
    parameter int                ALIGN_BITS     = 2,
    parameter bit                CLR_ON_DISABLE = 1'b1,
    parameter int                CNT_W          = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_trap,
    input  logic [XLEN-1:0]   i_trap_target,
    input  logic              i_br_taken,
    input  logic [XLEN-1:0]   i_br_target,
    input  logic              i_halt,
    input  logic              i_resume,
    input  logic              i_stall,
    input  logic              i_fetch_ready,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_pc_plus,
    output logic              o_fetch_valid,
    output logic              o_misaligned,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_fetch_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Mask of the low ALIGN_BITS bits; written this way so ALIGN_BITS=0 works.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [CNT_W-1:0]  r_fetch_cnt;
    logic              r_misaligned;
    logic              r_halted;

    logic              w_fetch_valid;
    logic              w_fire;
    logic [XLEN-1:0]   w_trap_aligned;
    logic              w_br_misaligned;

    assign w_fetch_valid   = (r_state == ST_RUN) & i_en & ~i_stall;
    assign w_fire          = w_fetch_valid & i_fetch_ready;
    assign w_trap_aligned  = i_trap_target & ~LOW_MASK;
    assign w_br_misaligned = (i_br_target & LOW_MASK) != {XLEN{1'b0}};

    // FSM, PC, fetch counter and status flags resolved by fixed priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_fetch_cnt  <= {CNT_W{1'b0}};
            r_misaligned <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            if (!i_en) begin
                // Disabled: state and counter hold; PC clears or holds.
                if (CLR_ON_DISABLE) begin
                    r_pc <= RESET_VECTOR;
                end else begin
                    r_pc <= r_pc;
                end
            end else if (i_trap) begin
                // In BOOT the unconditional BOOT->RUN step lands in RUN as well.
                r_pc     <= w_trap_aligned;
                r_state  <= ST_RUN;
                r_halted <= 1'b0;
            end else begin
                case (r_state)
                    ST_BOOT: begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                    ST_RUN: begin
                        if (i_br_taken && w_br_misaligned) begin
                            // Misaligned target is diverted to the trap handler.
                            r_pc         <= w_trap_aligned;
                            r_misaligned <= 1'b1;
                        end else if (i_br_taken) begin
                            r_pc <= i_br_target;
                        end else if (i_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (w_fire) begin
                            r_pc        <= r_pc + XLEN'(INC);
                            r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
                        end else begin
                            r_pc <= r_pc;
                        end
                    end
                    ST_HALT: begin
                        if (i_resume) begin
                            r_state  <= ST_RUN;
                            r_halted <= 1'b0;
                        end else begin
                            r_state <= ST_HALT;
                        end
                    end
                    default: begin
                        r_state  <= ST_BOOT;
                        r_halted <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pc          = r_pc;
    assign o_pc_plus     = r_pc + XLEN'(INC);
    assign o_fetch_valid = w_fetch_valid;
    assign o_misaligned  = r_misaligned;
    assign o_halted      = r_halted;
    assign o_fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen - directed self-checking bench for pc_gen
//
// Three instances share stimulus: u_dut (defaults), u_hold (CLR_ON_DISABLE=0)
// and u_nar (XLEN=8, CNT_W=2) for wrap-around cases. Inputs change 2 ns after
// the rising edge; outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, trap, br_taken, halt, resume, stall, fetch_ready;
    logic [31:0] trap_target, br_target;

    logic [31:0] a_pc, a_pc_plus, a_cnt;
    logic        a_valid, a_mis, a_halted;
    logic [31:0] b_pc, b_pc_plus, b_cnt;
    logic        b_valid, b_mis, b_halted;
    logic [7:0]  c_pc, c_pc_plus;
    logic [1:0]  c_cnt;
    logic        c_valid, c_mis, c_halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_gen u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_trap(trap),
        .i_trap_target(trap_target), .i_br_taken(br_taken), .i_br_target(br_target),
        .i_halt(halt), .i_resume(resume), .i_stall(stall), .i_fetch_ready(fetch_ready),
        .o_pc(a_pc), .o_pc_plus(a_pc_plus), .o_fetch_valid(a_valid),
        .o_misaligned(a_mis), .o_halted(a_halted), .o_fetch_cnt(a_cnt)
    );

    pc_gen #(.CLR_ON_DISABLE(1'b0)) u_hold (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_trap(trap),
        .i_trap_target(trap_target), .i_br_taken(br_taken), .i_br_target(br_target),
        .i_halt(halt), .i_resume(resume), .i_stall(stall), .i_fetch_ready(fetch_ready),
        .o_pc(b_pc), .o_pc_plus(b_pc_plus), .o_fetch_valid(b_valid),
        .o_misaligned(b_mis), .o_halted(b_halted), .o_fetch_cnt(b_cnt)
    );

    pc_gen #(.XLEN(8), .RESET_VECTOR(8'h00), .CNT_W(2)) u_nar (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_trap(trap),
        .i_trap_target(trap_target[7:0]), .i_br_taken(br_taken), .i_br_target(br_target[7:0]),
        .i_halt(halt), .i_resume(resume), .i_stall(stall), .i_fetch_ready(fetch_ready),
        .o_pc(c_pc), .o_pc_plus(c_pc_plus), .o_fetch_valid(c_valid),
        .o_misaligned(c_mis), .o_halted(c_halted), .o_fetch_cnt(c_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves the bench 2 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; trap = 1'b0; br_taken = 1'b0; halt = 1'b0;
        resume = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        trap_target = 32'h0; br_target = 32'h0;
        #13;
        check_eq("rst_pc",     {32'h0, a_pc},     64'h0);
        check_eq("rst_valid",  {63'h0, a_valid},  64'h0);
        check_eq("rst_mis",    {63'h0, a_mis},    64'h0);
        check_eq("rst_halted", {63'h0, a_halted}, 64'h0);
        check_eq("rst_cnt",    {32'h0, a_cnt},    64'h0);

        // Release reset away from an edge; BOOT lasts one cycle.
        @(negedge clk); rst_n = 1'b1; #1;
        check_eq("boot_pc",    {32'h0, a_pc},    64'h0);
        check_eq("boot_valid", {63'h0, a_valid}, 64'h0);
        tick(); #1;
        check_eq("run0_pc",    {32'h0, a_pc},    64'h0);
        check_eq("run0_valid", {63'h0, a_valid}, 64'h1);
        check_eq("pc_plus",    {32'h0, a_pc_plus}, 64'h4);
        tick(); #1; check_eq("seq_pc4",  {32'h0, a_pc}, 64'h4);
        tick(); #1; check_eq("seq_pc8",  {32'h0, a_pc}, 64'h8);
        tick(); #1; check_eq("seq_pc12", {32'h0, a_pc}, 64'hC);
        check_eq("seq_cnt3", {32'h0, a_cnt}, 64'h3);
        tick(); #1; check_eq("seq_pc16", {32'h0, a_pc}, 64'h10);

        // imem back-pressure: request stays stable with valid high.
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("bp_pc",    {32'h0, a_pc},    64'h10);
            check_eq("bp_valid", {63'h0, a_valid}, 64'h1);
            check_eq("bp_cnt",   {32'h0, a_cnt},   64'h4);
        end
        fetch_ready = 1'b1;
        tick(); #1;
        check_eq("bp_rel_pc",  {32'h0, a_pc},  64'h14);
        check_eq("bp_rel_cnt", {32'h0, a_cnt}, 64'h5);

        // Branch together with stall: redirect still applies, no count.
        br_taken = 1'b1; br_target = 32'h200; stall = 1'b1;
        tick(); br_taken = 1'b0; stall = 1'b0; #1;
        check_eq("br_pc",    {32'h0, a_pc},    64'h200);
        check_eq("br_cnt",   {32'h0, a_cnt},   64'h5);
        check_eq("br_valid", {63'h0, a_valid}, 64'h1);

        // Misaligned branch diverts to the aligned trap target.
        br_taken = 1'b1; br_target = 32'h202; trap_target = 32'h80;
        tick(); br_taken = 1'b0; #1;
        check_eq("mis_pc",  {32'h0, a_pc},  64'h80);
        check_eq("mis_hi",  {63'h0, a_mis}, 64'h1);
        check_eq("mis_cnt", {32'h0, a_cnt}, 64'h5);
        tick(); #1;
        check_eq("mis_lo",   {63'h0, a_mis}, 64'h0);
        check_eq("mis_next", {32'h0, a_pc},  64'h84);
        check_eq("mis_cnt6", {32'h0, a_cnt}, 64'h6);

        // Halt at 0x40; branches are ignored while halted.
        br_taken = 1'b1; br_target = 32'h40;
        tick(); br_taken = 1'b0; #1;
        check_eq("h_pre_pc", {32'h0, a_pc}, 64'h40);
        halt = 1'b1;
        tick(); halt = 1'b0; #1;
        check_eq("h_halted", {63'h0, a_halted}, 64'h1);
        check_eq("h_cnt",    {32'h0, a_cnt},    64'h6);
        br_taken = 1'b1; br_target = 32'h300;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            check_eq("h_pc",    {32'h0, a_pc},     64'h40);
            check_eq("h_valid", {63'h0, a_valid},  64'h0);
            check_eq("h_still", {63'h0, a_halted}, 64'h1);
        end
        br_taken = 1'b0;
        resume = 1'b1;
        tick(); resume = 1'b0; #1;
        check_eq("res_halted", {63'h0, a_halted}, 64'h0);
        check_eq("res_pc",     {32'h0, a_pc},     64'h40);
        check_eq("res_valid",  {63'h0, a_valid},  64'h1);
        tick(); #1;
        check_eq("res_adv", {32'h0, a_pc},  64'h44);
        check_eq("res_cnt", {32'h0, a_cnt}, 64'h7);

        // Halt wins over a simultaneous fire; trap leaves HALT.
        halt = 1'b1;
        tick(); halt = 1'b0; #1;
        check_eq("h2_pc", {32'h0, a_pc}, 64'h44);
        check_eq("h2_halted", {63'h0, a_halted}, 64'h1);
        trap = 1'b1; trap_target = 32'h123;
        tick(); trap = 1'b0; #1;
        check_eq("ht_pc",     {32'h0, a_pc},     64'h120);
        check_eq("ht_halted", {63'h0, a_halted}, 64'h0);
        check_eq("ht_valid",  {63'h0, a_valid},  64'h1);
        tick(); #1;
        check_eq("ht_adv", {32'h0, a_pc}, 64'h124);
        check_eq("ht_cnt", {32'h0, a_cnt}, 64'h8);

        // Trap + branch + fire: trap target wins, no count increment.
        trap = 1'b1; trap_target = 32'h500; br_taken = 1'b1; br_target = 32'h600;
        tick(); trap = 1'b0; br_taken = 1'b0; #1;
        check_eq("prio_pc",  {32'h0, a_pc},  64'h500);
        check_eq("prio_cnt", {32'h0, a_cnt}, 64'h8);

        // Disable at 0x100: clear vs hold variants.
        br_taken = 1'b1; br_target = 32'h100;
        tick(); br_taken = 1'b0; #1;
        check_eq("en_pre_pc", {32'h0, b_pc}, 64'h100);
        en = 1'b0; #1;
        check_eq("en_valid_a", {63'h0, a_valid}, 64'h0);
        check_eq("en_valid_b", {63'h0, b_valid}, 64'h0);
        tick(); #1;
        check_eq("en_clr_pc",  {32'h0, a_pc},  64'h0);
        check_eq("en_hold_pc", {32'h0, b_pc},  64'h100);
        check_eq("en_cnt",     {32'h0, a_cnt}, 64'h8);
        en = 1'b1;

        // Narrow instance: PC and counter wrap, then async reset.
        rst_n = 1'b0; #1;
        check_eq("c_rst_pc", {56'h0, c_pc}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        br_taken = 1'b1; br_target = 32'hFC;
        tick(); br_taken = 1'b0; #1;
        check_eq("c_fc_pc",  {56'h0, c_pc},  64'hFC);
        check_eq("c_fc_cnt", {62'h0, c_cnt}, 64'h0);
        tick(); #1;
        check_eq("c_wrap_pc",  {56'h0, c_pc},  64'h00);
        check_eq("c_wrap_cnt", {62'h0, c_cnt}, 64'h1);
        tick(); tick(); tick(); #1;
        check_eq("c_cnt_wrap", {62'h0, c_cnt}, 64'h0);
        check_eq("c_pc_c",     {56'h0, c_pc},  64'h0C);
        rst_n = 1'b0; #1;
        check_eq("async_c_pc",  {56'h0, c_pc},  64'h0);
        check_eq("async_c_cnt", {62'h0, c_cnt}, 64'h0);
        check_eq("async_a_pc",  {32'h0, a_pc},  64'h0);
        check_eq("async_a_cnt", {32'h0, a_cnt}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
